// File: rtl/alu_arbiter.sv
// alu_arbiter: shares one combinational 32-bit ALU between two requesters.
// Each requester has a valid/ready request channel and a valid/ready
// response channel. A single result register holds one result at a time.
// Throughput is one op per cycle and latency is one cycle.
//
// Parameters:
//   FIXED_PRIO  0: round-robin between requesters, 1: requester 0 always wins
// Ports:
//   clk, rst_n                 clock, synchronous active-low reset
//   req_valid[1:0]             requester i presents an operation
//   req_ready[1:0]             operation of requester i accepted this cycle (one-hot or 00)
//   req{0,1}_src_a/_src_b      operands (shift amount is src_b[4:0])
//   req{0,1}_op/_alt           ALU op and alt bit (sub, sra)
//   rsp_valid[1:0]             rsp_res belongs to requester i
//   rsp_ready[1:0]             requester i consumes the response
//   rsp_res[31:0]              registered ALU result, driven even when not valid
module alu_arbiter #(
  parameter int unsigned FIXED_PRIO = 0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [1:0]  req_valid,
  output logic [1:0]  req_ready,
  input  logic [31:0] req0_src_a,
  input  logic [31:0] req0_src_b,
  input  logic [2:0]  req0_op,
  input  logic        req0_alt,
  input  logic [31:0] req1_src_a,
  input  logic [31:0] req1_src_b,
  input  logic [2:0]  req1_op,
  input  logic        req1_alt,
  output logic [1:0]  rsp_valid,
  input  logic [1:0]  rsp_ready,
  output logic [31:0] rsp_res
);

  localparam logic [2:0] OpAdd  = 3'b000;
  localparam logic [2:0] OpSll  = 3'b001;
  localparam logic [2:0] OpSlt  = 3'b010;
  localparam logic [2:0] OpSltu = 3'b011;
  localparam logic [2:0] OpXor  = 3'b100;
  localparam logic [2:0] OpSrl  = 3'b101;
  localparam logic [2:0] OpOr   = 3'b110;
  localparam logic [2:0] OpAnd  = 3'b111;

  logic        slot_full_q, slot_full_d;
  logic        slot_owner_q, slot_owner_d;
  logic [31:0] slot_res_q, slot_res_d;
  logic        last_grant_q, last_grant_d;

  logic        drain;
  logic        can_accept;
  logic        accept;
  logic        grant_idx;

  logic [31:0] alu_a, alu_b, alu_res;
  logic [2:0]  alu_op;
  logic        alu_alt;
  logic [4:0]  shamt;

  // Owner's rsp_ready only; the non-owner bit is ignored.
  assign drain      = slot_full_q & rsp_ready[slot_owner_q];
  assign can_accept = ~slot_full_q | drain;

  always_comb begin
    req_ready = 2'b00;
    if (rst_n && can_accept) begin
      case (req_valid)
        2'b01:   req_ready = 2'b01;
        2'b10:   req_ready = 2'b10;
        2'b11: begin
          if (FIXED_PRIO != 0) begin
            req_ready = 2'b01;
          end else begin
            // Alternate away from the previous winner.
            req_ready = last_grant_q ? 2'b01 : 2'b10;
          end
        end
        default: req_ready = 2'b00;
      endcase
    end
  end

  assign accept    = |req_ready;
  assign grant_idx = req_ready[1];

  // Operand mux follows the grant so only one ALU is needed.
  always_comb begin
    if (grant_idx) begin
      alu_a   = req1_src_a;
      alu_b   = req1_src_b;
      alu_op  = req1_op;
      alu_alt = req1_alt;
    end else begin
      alu_a   = req0_src_a;
      alu_b   = req0_src_b;
      alu_op  = req0_op;
      alu_alt = req0_alt;
    end
  end

  assign shamt = alu_b[4:0];

  always_comb begin
    alu_res = 32'h0;
    case (alu_op)
      OpAdd:   alu_res = alu_alt ? (alu_a - alu_b) : (alu_a + alu_b);
      OpSll:   alu_res = alu_a << shamt;
      OpSlt:   alu_res = {31'b0, $signed(alu_a) < $signed(alu_b)};
      OpSltu:  alu_res = {31'b0, alu_a < alu_b};
      OpXor:   alu_res = alu_a ^ alu_b;
      OpSrl:   alu_res = alu_alt ? $unsigned($signed(alu_a) >>> shamt) : (alu_a >> shamt);
      OpOr:    alu_res = alu_a | alu_b;
      OpAnd:   alu_res = alu_a & alu_b;
      default: alu_res = 32'h0;
    endcase
  end

  // Accept takes priority over drain so that a same-cycle drain+accept
  // leaves the slot full with the new result (no bubble).
  always_comb begin
    slot_full_d  = slot_full_q;
    slot_owner_d = slot_owner_q;
    slot_res_d   = slot_res_q;
    last_grant_d = last_grant_q;
    if (accept) begin
      slot_full_d  = 1'b1;
      slot_owner_d = grant_idx;
      slot_res_d   = alu_res;
      last_grant_d = grant_idx;
    end else if (drain) begin
      slot_full_d  = 1'b0;
    end
  end

  // last_grant resets to 1 so requester 0 wins the first contended cycle.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      slot_full_q  <= 1'b0;
      slot_owner_q <= 1'b0;
      slot_res_q   <= 32'h0;
      last_grant_q <= 1'b1;
    end else begin
      slot_full_q  <= slot_full_d;
      slot_owner_q <= slot_owner_d;
      slot_res_q   <= slot_res_d;
      last_grant_q <= last_grant_d;
    end
  end

  assign rsp_valid = {slot_full_q & slot_owner_q, slot_full_q & ~slot_owner_q};
  assign rsp_res   = slot_res_q;

endmodule

// File: tb/tb_alu_arbiter.sv
// Self-checking bench for alu_arbiter: a round-robin and a fixed-priority
// instance share all inputs. A transaction-level reference model tracks the
// pending result of each instance; constant vector tables and hand sequences
// cover the ALU encodings and multi-cycle corners.
module tb_alu_arbiter;

  logic        clk;
  logic        rst_n;
  logic [1:0]  req_valid;
  logic [1:0]  rsp_ready;
  logic [31:0] req0_src_a, req0_src_b, req1_src_a, req1_src_b;
  logic [2:0]  req0_op, req1_op;
  logic        req0_alt, req1_alt;

  logic [1:0]  req_ready_rr, rsp_valid_rr, req_ready_fp, rsp_valid_fp;
  logic [31:0] rsp_res_rr, rsp_res_fp;

  int n_checks;
  int n_fail;
  logic chk_en;

  // Model: per instance (0 = round-robin, 1 = fixed priority), is a result
  // pending, whose is it, its value, and who won most recently.
  logic        m_full[2];
  logic        m_owner[2];
  logic [31:0] m_res[2];
  logic        m_last[2];

  logic [1:0]  obs_ready[2];
  logic [1:0]  obs_valid[2];
  logic [31:0] obs_res[2];

  alu_arbiter #(.FIXED_PRIO(0)) dut_rr (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready_rr),
    .req0_src_a(req0_src_a), .req0_src_b(req0_src_b), .req0_op(req0_op), .req0_alt(req0_alt),
    .req1_src_a(req1_src_a), .req1_src_b(req1_src_b), .req1_op(req1_op), .req1_alt(req1_alt),
    .rsp_valid(rsp_valid_rr), .rsp_ready(rsp_ready), .rsp_res(rsp_res_rr)
  );

  alu_arbiter #(.FIXED_PRIO(1)) dut_fp (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready_fp),
    .req0_src_a(req0_src_a), .req0_src_b(req0_src_b), .req0_op(req0_op), .req0_alt(req0_alt),
    .req1_src_a(req1_src_a), .req1_src_b(req1_src_b), .req1_op(req1_op), .req1_alt(req1_alt),
    .rsp_valid(rsp_valid_fp), .rsp_ready(rsp_ready), .rsp_res(rsp_res_fp)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] ref_alu(input logic [2:0] op, input logic alt,
                                          input logic [31:0] a, input logic [31:0] b);
    int unsigned s;
    logic [31:0] r;
    s = int'(b % 32);
    case (op)
      3'd0: r = alt ? a - b : a + b;
      3'd1: r = a << s;
      3'd2: r = (int'(a) < int'(b)) ? 32'd1 : 32'd0;
      3'd3: r = (a < b) ? 32'd1 : 32'd0;
      3'd4: r = a ^ b;
      3'd5: begin
        r = a >> s;
        if (alt && a >= 32'h8000_0000) r = r | ~(32'hFFFF_FFFF >> s);
      end
      3'd6: r = a | b;
      default: r = a & b;
    endcase
    return r;
  endfunction

  // Which requester the rules say gets the ALU this cycle, as a one-hot.
  function automatic logic [1:0] ref_grant(input int k);
    logic room;
    if (!rst_n) return 2'b00;
    room = !m_full[k] || (m_owner[k] ? rsp_ready[1] : rsp_ready[0]);
    if (!room) return 2'b00;
    if (req_valid == 2'b01) return 2'b01;
    if (req_valid == 2'b10) return 2'b10;
    if (req_valid == 2'b11) begin
      if (k == 1) return 2'b01;
      return (m_last[k] == 1'b0) ? 2'b10 : 2'b01;
    end
    return 2'b00;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Called at a falling edge with inputs already driven; returns at the next
  // falling edge after the model has followed the rising edge.
  task automatic cycle();
    logic [1:0] g[2];
    #1;
    obs_ready[0] = req_ready_rr; obs_valid[0] = rsp_valid_rr; obs_res[0] = rsp_res_rr;
    obs_ready[1] = req_ready_fp; obs_valid[1] = rsp_valid_fp; obs_res[1] = rsp_res_fp;
    for (int k = 0; k < 2; k++) begin
      g[k] = ref_grant(k);
      if (chk_en) begin
        check($sformatf("model_req_ready[%0d]", k), 32'(obs_ready[k]), 32'(g[k]));
        check($sformatf("model_rsp_valid[%0d]", k), 32'(obs_valid[k]),
              !m_full[k] ? 32'd0 : (m_owner[k] ? 32'd2 : 32'd1));
        check($sformatf("model_rsp_res[%0d]", k), obs_res[k], m_res[k]);
      end
    end
    @(posedge clk);
    for (int k = 0; k < 2; k++) begin
      if (!rst_n) begin
        m_full[k] = 1'b0; m_owner[k] = 1'b0; m_res[k] = 32'h0; m_last[k] = 1'b1;
      end else if (g[k] == 2'b01) begin
        m_full[k] = 1'b1; m_owner[k] = 1'b0; m_last[k] = 1'b0;
        m_res[k] = ref_alu(req0_op, req0_alt, req0_src_a, req0_src_b);
      end else if (g[k] == 2'b10) begin
        m_full[k] = 1'b1; m_owner[k] = 1'b1; m_last[k] = 1'b1;
        m_res[k] = ref_alu(req1_op, req1_alt, req1_src_a, req1_src_b);
      end else if (m_full[k] && (m_owner[k] ? rsp_ready[1] : rsp_ready[0])) begin
        m_full[k] = 1'b0;
      end
    end
    @(negedge clk);
  endtask

  typedef struct {
    logic        req;
    logic [2:0]  op;
    logic        alt;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
  } vec_t;

  vec_t vecs[13];

  initial begin
    vecs[0]  = '{1'b0, 3'd0, 1'b0, 32'd5,         32'd7,         32'h0000_000C};
    vecs[1]  = '{1'b1, 3'd0, 1'b1, 32'd3,         32'd5,         32'hFFFF_FFFE};
    vecs[2]  = '{1'b1, 3'd5, 1'b1, 32'h8000_0000, 32'd4,         32'hF800_0000};
    vecs[3]  = '{1'b1, 3'd5, 1'b0, 32'h8000_0000, 32'd4,         32'h0800_0000};
    vecs[4]  = '{1'b0, 3'd1, 1'b0, 32'd1,         32'd31,        32'h8000_0000};
    vecs[5]  = '{1'b0, 3'd1, 1'b0, 32'd1,         32'h21,        32'h0000_0002};
    vecs[6]  = '{1'b1, 3'd2, 1'b0, 32'hFFFF_FFFF, 32'd1,         32'h0000_0001};
    vecs[7]  = '{1'b1, 3'd3, 1'b0, 32'hFFFF_FFFF, 32'd1,         32'h0000_0000};
    vecs[8]  = '{1'b0, 3'd4, 1'b0, 32'hF0F0_F0F0, 32'hFF00_FF00, 32'h0FF0_0FF0};
    vecs[9]  = '{1'b0, 3'd6, 1'b0, 32'hF0F0_F0F0, 32'h0F00_000F, 32'hFFF0_F0FF};
    vecs[10] = '{1'b1, 3'd7, 1'b0, 32'hF0F0_F0F0, 32'hFF00_FF00, 32'hF000_F000};
    vecs[11] = '{1'b0, 3'd0, 1'b0, 32'hFFFF_FFFF, 32'd2,         32'h0000_0001};
    vecs[12] = '{1'b0, 3'd2, 1'b0, 32'd5,         32'd5,         32'h0000_0000};

    n_checks = 0; n_fail = 0; chk_en = 1'b0;
    rst_n = 1'b0; req_valid = 2'b00; rsp_ready = 2'b11;
    req0_src_a = '0; req0_src_b = '0; req0_op = '0; req0_alt = 1'b0;
    req1_src_a = '0; req1_src_b = '0; req1_op = '0; req1_alt = 1'b0;
    for (int k = 0; k < 2; k++) begin
      m_full[k] = 1'b0; m_owner[k] = 1'b0; m_res[k] = '0; m_last[k] = 1'b1;
    end

    @(negedge clk);
    cycle();
    chk_en = 1'b1;
    req_valid = 2'b11;
    cycle();
    check("reset_req_ready", 32'(obs_ready[0]), 32'd0);
    rst_n = 1'b1; req_valid = 2'b00;
    cycle();
    check("reset_rsp_valid", 32'(obs_valid[0]), 32'd0);
    check("reset_rsp_res", obs_res[0], 32'd0);

    // ALU encodings through a single requester, one op then one response cycle.
    for (int i = 0; i < 13; i++) begin
      rsp_ready = 2'b11;
      if (vecs[i].req) begin
        req1_op = vecs[i].op; req1_alt = vecs[i].alt;
        req1_src_a = vecs[i].a; req1_src_b = vecs[i].b; req_valid = 2'b10;
      end else begin
        req0_op = vecs[i].op; req0_alt = vecs[i].alt;
        req0_src_a = vecs[i].a; req0_src_b = vecs[i].b; req_valid = 2'b01;
      end
      cycle();
      check($sformatf("vec%0d_req_ready", i), 32'(obs_ready[0]), vecs[i].req ? 32'd2 : 32'd1);
      req_valid = 2'b00;
      cycle();
      check($sformatf("vec%0d_rsp_valid", i), 32'(obs_valid[0]), vecs[i].req ? 32'd2 : 32'd1);
      check($sformatf("vec%0d_rsp_res", i), obs_res[0], vecs[i].exp);
    end

    // Contention after reset: round-robin alternates, fixed priority sticks to 0.
    rst_n = 1'b0; req_valid = 2'b00;
    cycle();
    rst_n = 1'b1; req_valid = 2'b11; rsp_ready = 2'b11;
    req0_op = 3'd0; req0_alt = 1'b0; req0_src_a = 32'd10; req0_src_b = 32'd1;
    req1_op = 3'd0; req1_alt = 1'b0; req1_src_a = 32'd20; req1_src_b = 32'd2;
    for (int i = 0; i < 4; i++) begin
      cycle();
      check($sformatf("rr_grant%0d", i), 32'(obs_ready[0]), (i % 2 == 0) ? 32'd1 : 32'd2);
      check($sformatf("fp_grant%0d", i), 32'(obs_ready[1]), 32'd1);
      if (i > 0)
        check($sformatf("rr_owner%0d", i), 32'(obs_valid[0]), (i % 2 == 1) ? 32'd1 : 32'd2);
    end
    req_valid = 2'b00;
    cycle();

    // Backpressure on requester 0, then drain and accept in the same cycle.
    req_valid = 2'b01; rsp_ready = 2'b11;
    req0_op = 3'd0; req0_alt = 1'b0; req0_src_a = 32'h100; req0_src_b = 32'h23;
    cycle();
    check("bp_accept", 32'(obs_ready[0]), 32'd1);
    req_valid = 2'b11; rsp_ready = 2'b10;
    for (int i = 0; i < 3; i++) begin
      cycle();
      check($sformatf("bp_ready%0d", i), 32'(obs_ready[0]), 32'd0);
      check($sformatf("bp_valid%0d", i), 32'(obs_valid[0]), 32'd1);
      check($sformatf("bp_res%0d", i), obs_res[0], 32'h123);
    end
    req_valid = 2'b10; rsp_ready = 2'b01;
    req1_op = 3'd6; req1_alt = 1'b0; req1_src_a = 32'hA0; req1_src_b = 32'h0B;
    cycle();
    check("bp_drain_accept_ready", 32'(obs_ready[0]), 32'd2);
    check("bp_drain_accept_valid", 32'(obs_valid[0]), 32'd1);
    req_valid = 2'b00; rsp_ready = 2'b00;
    cycle();
    check("bp_next_valid", 32'(obs_valid[0]), 32'd2);
    check("bp_next_res", obs_res[0], 32'h0000_00AB);

    // Reset with a result pending for requester 1.
    rst_n = 1'b0;
    cycle();
    check("rst_mid_ready", 32'(obs_ready[0]), 32'd0);
    rst_n = 1'b1; req_valid = 2'b11;
    cycle();
    check("rst_mid_valid", 32'(obs_valid[0]), 32'd0);
    check("rst_mid_res", obs_res[0], 32'd0);
    check("rst_mid_grant", 32'(obs_ready[0]), 32'd1);
    req_valid = 2'b00; rsp_ready = 2'b11;
    cycle();
    check("rst_mid_owner", 32'(obs_valid[0]), 32'd1);

    // Round-robin restarts even when requester 0 won last before reset.
    req_valid = 2'b01;
    cycle();
    rst_n = 1'b0; req_valid = 2'b00;
    cycle();
    rst_n = 1'b1; req_valid = 2'b11;
    cycle();
    check("rst_rr_restart", 32'(obs_ready[0]), 32'd1);

    // Random traffic against the model.
    for (int i = 0; i < 600; i++) begin
      rst_n      = ($urandom_range(0, 59) != 0);
      req_valid  = 2'($urandom_range(0, 3));
      rsp_ready  = ($urandom_range(0, 3) == 0) ? 2'($urandom_range(0, 3)) : 2'b11;
      req0_op    = 3'($urandom_range(0, 7)); req0_alt = 1'($urandom_range(0, 1));
      req1_op    = 3'($urandom_range(0, 7)); req1_alt = 1'($urandom_range(0, 1));
      req0_src_a = $urandom; req0_src_b = $urandom;
      req1_src_a = $urandom; req1_src_b = ($urandom_range(0, 1) != 0) ? $urandom : req1_src_a;
      cycle();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
